// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_BYTES  = 2;
  localparam int CNT_W      = 8 * CNT_BYTES;

  typedef enum logic [2:0] {
    S_CNT0 = 3'd0,
    S_CNT1 = 3'd1,
    S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // True when an image of 'count' words fits between the base address and the top of memory.
  function automatic logic count_fits(input logic [CNT_W-1:0] count, input int limit);
    return int'(count) <= limit;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input link plus instruction-memory write port of the loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// 8->32 little-endian word assembler; o_word_valid fires combinationally with the 4th byte.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam logic [1:0] IDX_LAST = 2'(WORD_BYTES - 1);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_lanes;

  // NOTE: only the byte index is reset; the lane registers are pure datapath,
  // and a stale lane can never escape because byte_idx restarts at 0.
  always_ff @(posedge clk) begin
    if (RESET || i_clear) begin
      r_byte_idx <= 2'd0;
    end else if (i_push) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_lanes[7:0]   <= i_data;
        2'd1:    r_lanes[15:8]  <= i_data;
        2'd2:    r_lanes[23:16] <= i_data;
        default: ;
      endcase
    end
  end

  assign o_word       = {i_data, r_lanes};
  assign o_word_valid = i_push && (r_byte_idx == IDX_LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count header + payload, writes instruction memory, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         RESET,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         done,
  output logic         error
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LIMIT  = DEPTH - BASE_ADDR;
  localparam int WIDX_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER   = S_CSUM;
  localparam logic   END_READY = 1'b1;
`else
  localparam state_t S_AFTER   = S_DONE;
  localparam logic   END_READY = 1'b0;
`endif

  state_t              r_state;
  logic [7:0]          r_cnt_lo;
  logic [WIDX_W-1:0]   r_count;
  logic [WIDX_W-1:0]   r_word_idx;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_core_rst;
  logic                r_done;
  logic                r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_xfer;
  logic                w_push;
  logic                w_clear;
  logic [CNT_W-1:0]    w_count;
  logic [31:0]         w_word;
  logic                w_word_valid;
  logic                w_last;

  assign w_xfer  = bus.in_valid && r_in_ready;
  assign w_push  = w_xfer && (r_state == S_DATA);
  assign w_clear = (r_state != S_DATA);
  assign w_count = {bus.in_data, r_cnt_lo};
  assign w_last  = w_word_valid && ((r_word_idx + WIDX_W'(1)) == r_count);

  imem_loader_byte_assembler u_asm (
    .clk          (clk),
    .RESET        (RESET),
    .i_clear      (w_clear),
    .i_push       (w_push),
    .i_data       (bus.in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // NOTE: every register here uses <= so all state updates see the pre-edge
  // values; a blocking assignment would leak new values into later statements.
  // done/core_rst/error follow the state by one cycle, which is what puts the
  // core release strictly after the final memory write.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state     <= S_CNT0;
      r_cnt_lo    <= 8'd0;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_W'(BASE_ADDR);
      r_mem_wdata <= 32'd0;
      r_core_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_CNT0: if (w_xfer) begin
          r_cnt_lo <= bus.in_data;
          r_state  <= S_CNT1;
        end
        S_CNT1: if (w_xfer) begin
          r_count <= WIDX_W'(w_count);
          if (!count_fits(w_count, LIMIT)) begin
            r_state    <= S_ERR;
            r_in_ready <= 1'b0;
          end else if (w_count == '0) begin
            r_state    <= S_AFTER;
            r_in_ready <= END_READY;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_word_valid) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= ADDR_W'(BASE_ADDR) + r_word_idx[ADDR_W-1:0];
          r_mem_wdata <= w_word;
          r_word_idx  <= r_word_idx + WIDX_W'(1);
          if (w_last) begin
            r_state    <= S_AFTER;
            r_in_ready <= END_READY;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: if (w_xfer) begin
          r_in_ready <= 1'b0;
          r_state    <= (bus.in_data == r_csum) ? S_DONE : S_ERR;
        end
`endif
        S_DONE: begin
          r_done     <= 1'b1;
          r_core_rst <= 1'b0;
        end
        S_ERR: begin
          r_error <= 1'b1;
        end
        default: begin
          r_state    <= S_ERR;
          r_in_ready <= 1'b0;
        end
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_xfer && (r_state != S_CSUM)) r_csum <= r_csum ^ bus.in_data;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign core_rst      = r_core_rst;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frame-level reference model feeds an expected-write queue.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic RESET;
  logic core_rst, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and times the core release.
  int   cycle   = 0;
  int   last_we = -100;
  logic prev_core_rst = 1'b1;
  always @(negedge clk) begin
    wr_t e;
    cycle++;
    if (RESET) begin
      last_we = -100;
    end else begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing expected",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(bus.mem_addr), 64'(e.addr));
          check("write_data", 64'(bus.mem_wdata), 64'(e.data));
        end
        last_we = cycle;
      end
      if (prev_core_rst && !core_rst && last_we >= 0)
        check("core_rst_release_lag", 64'(cycle - last_we), 64'd1);
    end
    prev_core_rst = core_rst;
  end

  // Reference model: 0 = loads and releases, 1 = error, 2 = frame incomplete.
  function automatic int model(input byte_q_t b);
    int n;
    logic [7:0] x;
    if (b.size() < 2) return 2;
    n = int'({b[1], b[0]});
    if (n > DEPTH - BASE_ADDR) return 1;
    for (int w = 0; w < n; w++) begin
      if (b.size() < 2 + 4 * w + 4) return 2;
      exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + w),
                        data: {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]}});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (b.size() < 2 + 4 * n + 1) return 2;
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= b[i];
    return (b[2+4*n] == x) ? 0 : 1;
`else
    x = 8'd0;
    return int'(x);
`endif
  endfunction

  function automatic byte_q_t with_csum(input byte_q_t b);
    byte_q_t r = b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'd0;
    foreach (b[i]) x ^= b[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  function automatic byte_q_t rand_frame(input int n);
    byte_q_t b;
    logic [15:0] n16 = 16'(n);
    b.push_back(n16[7:0]);
    b.push_back(n16[15:8]);
    for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] v, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_mem_we",    64'(bus.mem_we),    64'd0);
    check("rst_mem_addr",  64'(bus.mem_addr),  64'(BASE_ADDR));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_core_rst",  64'(core_rst),      64'd1);
    check("rst_done",      64'(done),          64'd0);
    check("rst_error",     64'(error),         64'd0);
    RESET = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t b, input int max_gap);
    foreach (b[i]) send_byte(b[i], int'($urandom_range(max_gap, 0)));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input byte_q_t b, input int max_gap);
    int outcome;
    int waited;
    do_reset();
    outcome = model(b);
    send_bytes(b, max_gap);
    waited = 0;
    while (!(done || error) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done=%0b error=%0b after %0d cycles", name, done, error, waited);
    end
    // Trailing junk must be refused once the loader has finished.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_done"},     64'(done),         64'(outcome == 0));
    check({name, "_error"},    64'(error),        64'(outcome == 1));
    check({name, "_core_rst"}, 64'(core_rst),     64'(outcome != 0));
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({name, "_pending"},  64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    byte_q_t b;
    RESET        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    b = '{8'h03, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00, 8'h13, 8'h82,
          8'hC1, 8'h00, 8'h33, 8'h83, 8'h32, 8'h40};
    run_frame("three_words", with_csum(b), 0);
    run_frame("three_words_gaps", with_csum(b), 5);
    run_frame("empty_image", with_csum('{8'h00, 8'h00}), 0);

    b = '{8'h2C, 8'h01};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    run_frame("oversize", b, 2);

    // Abort two bytes into word 0, then load a fresh one-word image.
    do_reset();
    b = '{8'h01, 8'h00, 8'hAA, 8'h55};
    void'(model(b));
    send_bytes(b, 1);
    run_frame("after_abort", with_csum('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}), 0);

    for (int k = 0; k < 4; k++)
      run_frame("random", with_csum(rand_frame(int'($urandom_range(16, 1)))), 3);

    run_frame("full_depth", with_csum(rand_frame(DEPTH - BASE_ADDR)), 0);
    run_frame("depth_plus_one", rand_frame(DEPTH - BASE_ADDR + 1), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_frame("csum_good", '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12}, 0);
    run_frame("csum_bad",  '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    b = with_csum(rand_frame(5));
    b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    run_frame("csum_rand_bad", b, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
